// File: rtl/lth_serial.sv
// Bit-serial signed less-than / equality comparator.
// Scans captured operands MSB-first, one bit per clock, and pulses done with r = (x < y), eq = (x == y).
module lth_serial #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  output logic                    busy,
  output logic                    done,
  output logic                    r,
  output logic                    eq
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    DEC_UND,
    DEC_LT,
    DEC_GT
  } dec_t;

  state_t                    state, state_nxt;
  dec_t                      dec, dec_step;
  logic        [CNT_W-1:0]   cnt;
  logic signed [WIDTH-1:0]   xs, ys;
  logic                      accept;
  logic                      last_bit;
  logic                      sign_bit;

  // The sign bit weighs negatively, so its verdict is inverted relative to lower bits.
  function automatic dec_t next_dec(input dec_t cur, input logic is_sign,
                                    input logic xb, input logic yb);
    dec_t res;
    res = cur;
    if (cur == DEC_UND && xb != yb) begin
      if (is_sign) res = xb ? DEC_LT : DEC_GT;
      else         res = xb ? DEC_GT : DEC_LT;
    end
    return res;
  endfunction

  assign accept   = (state == ST_IDLE) && start;
  assign last_bit = (cnt == '0);
  assign sign_bit = (cnt == CNT_W'(WIDTH - 1));
  assign dec_step = next_dec(dec, sign_bit, xs[cnt], ys[cnt]);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)    state_nxt = ST_RUN;
      ST_RUN:  if (last_bit) state_nxt = ST_DONE;
      ST_DONE:               state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      dec   <= DEC_UND;
      r     <= 1'b0;
      eq    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      done  <= (state_nxt == ST_DONE);
      if (accept) begin
        cnt <= CNT_W'(WIDTH - 1);
        dec <= DEC_UND;
      end else if (state == ST_RUN) begin
        dec <= dec_step;
        if (last_bit) begin
          r  <= (dec_step == DEC_LT);
          eq <= (dec_step == DEC_UND);
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

  // Operand capture is pure data and carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      xs <= x;
      ys <= y;
    end
  end

endmodule

// File: doc/lth_serial.md
Name: lth_serial

Overview:
- Bit-serial, multi-cycle signed less-than comparator. It is the sequential counterpart of the combinational 8-bit signed comparator.
- Captures two two's-complement operands on a start handshake and scans them MSB-first, one bit per clock.
- Reports r = (x < y) and eq = (x == y) with a one-cycle done pulse.
- Used where comparator area matters more than latency. It is also the sequential reference model driven by the same +x/+y directed benches.

Parameters:
- WIDTH, 8, operand width in bits, two's-complement signed; legal range 2..32.

Ports:
- clk    input   1      system clock, all state updates on rising edge
- rst_n  input   1      synchronous active-low reset
- start  input   1      request; sampled only in IDLE
- x      input   WIDTH  signed operand x, captured when start accepted
- y      input   WIDTH  signed operand y, captured when start accepted
- busy   output  1      high in RUN and DONE
- done   output  1      one-cycle pulse, high only in DONE
- r      output  1      result x < y (signed), valid from done, held until next completion
- eq     output  1      result x == y, same timing as r

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE; busy=0, done=0, r=0, eq=0; counter and decision cleared. Reset has priority over every other event, including mid-RUN and in DONE. Any operation in progress is abandoned with no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge captures x→xs and y→ys, sets cnt=WIDTH-1 and dec=UND, and moves to RUN. start=0 stays in IDLE.
  - RUN: each edge processes bit cnt of xs/ys, then decrements cnt. The edge that processes bit 0 loads r and eq from the final decision and moves to DONE.
  - DONE: exactly one cycle, done=1. The next edge always returns to IDLE.
- start is ignored in RUN and DONE. There is no queueing. A new request may be accepted at the earliest in the cycle after DONE.
- x and y are don't-care outside the accepting edge. Changes during RUN do not affect the result.
- Latency: start accepted at edge 0; bits processed at edges 1..WIDTH; done high in the cycle following edge WIDTH. Throughput is one comparison per WIDTH+2 cycles.
- Decision register dec ∈ {UND, LT, GT}. Once LT or GT is reached, it holds until the next accepted start.
  - Sign bit (cnt=WIDTH-1): xs=1, ys=0 → LT; xs=0, ys=1 → GT; equal bits → UND.
  - Lower bits, only while dec=UND: xs=0, ys=1 → LT; xs=1, ys=0 → GT; equal bits → UND.
  - Final outputs: r = (dec==LT); eq = (dec==UND). r and eq are never both 1.
- r and eq change only at the DONE-entry edge or at reset. They hold their values through IDLE and the next RUN.
- busy is registered: busy = (state != IDLE).
- Boundary conditions:
  - Most-negative vs most-positive operands resolve on the sign bit.
  - Equal operands run the full WIDTH cycles and give eq=1, r=0.
  - cnt never wraps: cnt reaching 0 forces the transition to DONE.

Test Plan:
- x=5, y=-7, pulse start → busy=1 for 9 cycles; done=1 exactly 8 cycles after the accepting edge; r=0, eq=0. Swap to x=-7, y=5 → r=1, eq=0.
- x=-128, y=127 → r=1. Then x=127, y=-128 → r=0. Both decided at the sign bit, with identical latency.
- x=-1, y=-1, then x=0, y=0 → r=0, eq=1 in both cases. Also x=-2, y=-1 → r=1 (decided at bit 0).
- x=3, y=4 accepted; during RUN drive start=1 and change x=100, y=-100 every cycle → a single done pulse; r=1 (captured operands used). The extra start pulses produce no second run.
- Start with x=-5, y=6; assert rst_n=0 for one edge at cycle 4 of RUN → next cycle state=IDLE, busy=0, done=0, r=0, eq=0, with no done pulse. A fresh start x=6, y=-5 then gives r=0.
- Back-to-back: hold start=1 continuously with x=1, y=2 → done pulses every 10 cycles (WIDTH+2); r=1 throughout after the first completion; busy low for exactly one cycle between runs.
